display_scan_mux: RTL

//   Time-multiplexed scan driver for an N-digit common-anode 7-segment display.

---
 rtl/display_scan_mux.sv | 68 ++++++
 1 files changed

// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed N-digit 7-segment scan driver with frame-aligned value updates.
// Optional LEADING_ZERO_BLANK_EN darkens digits above the most significant nonzero digit.
module display_scan_mux #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   num,
    output logic [3:0]              bcd,
    output logic [N_DIGITS-1:0]     an,
    output logic                    pending
);
    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;

    logic [DIV_W-1:0]      div_q, div_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] shadow_q, shadow_d, disp_q, disp_d;
    logic                  pending_q, pending_d;
    logic                  tick, wrap, lit;

    assign tick = en && div_q == DIV_W'(REFRESH_DIV - 1);
    assign wrap = tick && idx_q == IDX_W'(N_DIGITS - 1);

    always_comb begin
        div_d     = tick ? '0 : en ? div_q + 1'b1 : div_q;
        idx_d     = wrap ? '0 : tick ? idx_q + 1'b1 : idx_q;
        shadow_d  = load ? num : shadow_q;
        // A load coinciding with the boundary bypasses the stale shadow
        disp_d    = wrap && load ? num : wrap && pending_q ? shadow_q : disp_q;
        pending_d = wrap ? 1'b0 : load ? 1'b1 : pending_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd;
    always_comb begin
        msd = '0;
        for (int k = 1; k < N_DIGITS; k++)
            if (disp_q[4*k +: 4] != 4'h0) msd = IDX_W'(k);
    end
    assign lit = idx_q <= msd;
`else
    assign lit = 1'b1;
`endif

    assign bcd     = disp_q[4*idx_q +: 4];
    assign an      = en && lit ? ~(N_DIGITS'(1) << idx_q) : '1;
    assign pending = pending_q;
endmodule
